alu_issue: RTL and testbench
============================

# alu_issue

Issue and writeback sequencer for the CPU execute stage. It accepts one decoded ALU instruction through a valid/ready handshake and fetches its operands over several cycles from the register file's single synchronous read port. It then drives the ALU's operand, opcode and `alu_active` inputs, and writes the combinational ALU result back to the register file. It sits between the decoder (upstream) and the ALU/register file (downstream).

## Interface
- `DATA_WIDTH`, 16: operand, result and register width.
- `OPCODE_WIDTH`, 4: ALU opcode width.
- `REG_ADDR_WIDTH`, 3: register file address width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `instr_valid` in 1: decoder presents an instruction.
- `instr_ready` out 1: block can accept an instruction.
- `instr_opcode` in OPCODE_WIDTH: ALU opcode.
- `instr_rd`, `instr_ra`, `instr_rb` in REG_ADDR_WIDTH: destination and source registers.
- `instr_use_imm` in 1: use the immediate as operand B. Present only with `ALU_ISSUE_IMM_EN`.
- `instr_imm` in DATA_WIDTH: immediate value. Present only with `ALU_ISSUE_IMM_EN`.
- `rf_raddr` out REG_ADDR_WIDTH: register file read address. Data returns on `rf_rdata` one cycle later.
- `rf_rdata` in DATA_WIDTH: registered read data.
- `alu_op_a`, `alu_op_b` out DATA_WIDTH: registered ALU operands.
- `alu_opcode` out OPCODE_WIDTH: registered ALU opcode.
- `alu_active` out 1: one-cycle ALU strobe, used by the ALU for compare-flag update.
- `alu_result` in DATA_WIDTH: combinational ALU result.
- `rf_we` out 1: register file write enable.
- `rf_waddr` out REG_ADDR_WIDTH: write address.
- `rf_wdata` out DATA_WIDTH: write data.
- `busy` out 1: high in every state except IDLE.

## Operation
- The FSM states are IDLE, RD_A, RD_B, CAP_B and EXEC.
- **IDLE**
  - `instr_ready` = 1.
  - On `instr_valid` && `instr_ready`, latch opcode, rd, ra, rb (and use_imm, imm) and go to RD_A.
- **RD_A**
  - `rf_raddr` = ra.
  - Go to RD_B.
- **RD_B**
  - Latch `rf_rdata` into `alu_op_a`.
  - `rf_raddr` = rb.
  - If use_imm: load imm into `alu_op_b` and go to EXEC. Otherwise go to CAP_B.
- **CAP_B**
  - Latch `rf_rdata` into `alu_op_b`.
  - Go to EXEC.
- **EXEC**
  - `alu_active` = 1.
  - `rf_we` = 1 iff `alu_opcode[3]` == 0 (arithmetic/logic opcodes 0000–0111).
  - `rf_waddr` = rd; `rf_wdata` = `alu_result`.
  - Go to IDLE.
- Compare (1000) and opcodes 1001–1111 pulse `alu_active` but never write.
- `alu_opcode` is loaded at acceptance and holds until the next acceptance.
- `alu_op_a`/`alu_op_b` hold their values between instructions.
- `rf_raddr` holds its last value outside RD_A/RD_B.
- `instr_valid` is ignored outside IDLE; the decoder holds its fields until accepted.
- ra == rb or rd == ra needs no special handling: the write lands in EXEC, after both reads.

## Timing
- Acceptance edge at cycle T. RD_A is T+1, RD_B is T+2, CAP_B is T+3, EXEC is T+4. `instr_ready` is high again at T+5.
- Register-mode throughput is one instruction per 5 cycles.
- Immediate mode: EXEC is at T+3, throughput is one per 4 cycles.
- `rf_we` and `alu_active` are high for exactly one cycle per instruction, both in EXEC.
- A back-to-back instruction accepted at T+5 reads the value written at T+4; the register file writes at the EXEC edge.
- Reset values:
  - state IDLE.
  - `alu_op_a`, `alu_op_b`, `alu_opcode`, `rf_raddr`, `rf_waddr` = 0.
  - `alu_active`, `rf_we`, `busy` = 0.
  - `instr_ready` = 0 while `rst` is high, and 1 in the first cycle after `rst` falls.
- `rst` asserted in any state, including EXEC: at the next edge the state is IDLE and the in-flight instruction is dropped. No write occurs in a cycle where `rst` is high.

## Configuration
- `ALU_ISSUE_IMM_EN` defined:
  - `instr_use_imm` and `instr_imm` ports exist.
  - With use_imm = 1, operand B comes from the immediate and the CAP_B state is skipped.
- `ALU_ISSUE_IMM_EN` undefined:
  - Both ports are absent.
  - Every instruction takes the register path through CAP_B.

## Test plan
- **Reset:** hold `rst` for 3 cycles mid-CAP_B → no `rf_we`, `busy` = 0, `instr_ready` = 1 one cycle after release, `alu_op_a` = 0.
- **Add:** R1 = 5, R2 = 7, instr ADD (0000) rd = 3, ra = 1, rb = 2 → `rf_raddr` 1 at T+1 and 2 at T+2; at T+4 `rf_we` = 1, `rf_waddr` = 3, `rf_wdata` = 12.
- **Compare:** CMP (1000) with R1 = 5, R2 = 5 → `alu_active` = 1 at T+4, `rf_we` = 0; ALU `equal` = 1 at T+5.
- **Back-to-back dependency:** SUB R4 = R2 − R1, then NEG (0111) R5 = R4 presented continuously → second instruction accepted at T+5, writes R5 = 0xFFFE at T+9.
- **Immediate (macro on):** ADD use_imm, imm = 0x0010, ra = 1 (R1 = 5) → EXEC at T+3, `rf_wdata` = 0x0015.
- **Handshake:** `instr_valid` toggled during busy cycles → no acceptance until IDLE, and latched fields are unchanged.

Source files
------------

// File: rtl/alu_issue_if.sv
// Decoder-to-issue instruction handshake for alu_issue.
// Optional immediate fields exist only when ALU_ISSUE_IMM_EN is defined.
interface alu_issue_if #(
  parameter int unsigned OPCODE_WIDTH   = 4,
  parameter int unsigned REG_ADDR_WIDTH = 3
`ifdef ALU_ISSUE_IMM_EN
  , parameter int unsigned DATA_WIDTH   = 16
`endif
);
  logic                      instr_valid;
  logic                      instr_ready;
  logic [OPCODE_WIDTH-1:0]   instr_opcode;
  logic [REG_ADDR_WIDTH-1:0] instr_rd;
  logic [REG_ADDR_WIDTH-1:0] instr_ra;
  logic [REG_ADDR_WIDTH-1:0] instr_rb;
`ifdef ALU_ISSUE_IMM_EN
  logic                      instr_use_imm;
  logic [DATA_WIDTH-1:0]     instr_imm;
`endif

  // Decoder side
  modport master (
    output instr_valid, instr_opcode, instr_rd, instr_ra, instr_rb,
`ifdef ALU_ISSUE_IMM_EN
    output instr_use_imm, instr_imm,
`endif
    input  instr_ready
  );

  // Issue-sequencer side
  modport slave (
    input  instr_valid, instr_opcode, instr_rd, instr_ra, instr_rb,
`ifdef ALU_ISSUE_IMM_EN
    input  instr_use_imm, instr_imm,
`endif
    output instr_ready
  );
endinterface

// File: rtl/alu_issue.sv
// Issue and writeback sequencer for the execute stage.
// Accepts one instruction, reads ra then rb through the single synchronous
// register-file read port, strobes the ALU for one cycle and writes back.
// Optional feature macro: ALU_ISSUE_IMM_EN (immediate operand B, skips CAP_B).
module alu_issue #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned OPCODE_WIDTH   = 4,
  parameter int unsigned REG_ADDR_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  alu_issue_if.slave                instr,
  output logic [REG_ADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [DATA_WIDTH-1:0]     rf_rdata_i,
  output logic [DATA_WIDTH-1:0]     alu_op_a_o,
  output logic [DATA_WIDTH-1:0]     alu_op_b_o,
  output logic [OPCODE_WIDTH-1:0]   alu_opcode_o,
  output logic                      alu_active_o,
  input  logic [DATA_WIDTH-1:0]     alu_result_i,
  output logic                      rf_we_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0]     rf_wdata_o,
  output logic                      busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CAP_B,
    EXEC
  } state_e;

  state_e                    state_q;
  logic [OPCODE_WIDTH-1:0]   opcode_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [REG_ADDR_WIDTH-1:0] rb_q;
  logic [REG_ADDR_WIDTH-1:0] raddr_q;
  logic [REG_ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0]     op_a_q;
  logic [DATA_WIDTH-1:0]     op_b_q;
  logic                      active_q;
  logic                      we_q;
`ifdef ALU_ISSUE_IMM_EN
  logic                      use_imm_q;
  logic [DATA_WIDTH-1:0]     imm_q;
`endif

  // Sequencer FSM: state plus all registered datapath/strobe outputs.
  // alu_active/rf_we are set on the edge entering EXEC so they are high
  // exactly for the EXEC cycle; operands are already stable by then.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      rd_q      <= '0;
      rb_q      <= '0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      active_q  <= 1'b0;
      we_q      <= 1'b0;
`ifdef ALU_ISSUE_IMM_EN
      use_imm_q <= 1'b0;
      imm_q     <= '0;
`endif
    end else begin
      active_q <= 1'b0;
      we_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr.instr_valid) begin
            opcode_q  <= instr.instr_opcode;
            rd_q      <= instr.instr_rd;
            rb_q      <= instr.instr_rb;
            raddr_q   <= instr.instr_ra;
`ifdef ALU_ISSUE_IMM_EN
            use_imm_q <= instr.instr_use_imm;
            imm_q     <= instr.instr_imm;
`endif
            state_q   <= RD_A;
          end
        end
        RD_A: begin
          raddr_q <= rb_q;
          state_q <= RD_B;
        end
        RD_B: begin
          op_a_q  <= rf_rdata_i;
          state_q <= CAP_B;
`ifdef ALU_ISSUE_IMM_EN
          if (use_imm_q) begin
            op_b_q   <= imm_q;
            active_q <= 1'b1;
            we_q     <= ~opcode_q[OPCODE_WIDTH-1];
            waddr_q  <= rd_q;
            state_q  <= EXEC;
          end
`endif
        end
        CAP_B: begin
          op_b_q   <= rf_rdata_i;
          active_q <= 1'b1;
          we_q     <= ~opcode_q[OPCODE_WIDTH-1];
          waddr_q  <= rd_q;
          state_q  <= EXEC;
        end
        EXEC: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Handshake/status and strobe gating; a write is suppressed in any
  // cycle where rst is high, even if the FSM is sitting in EXEC.
  always_comb begin
    instr.instr_ready = (state_q == IDLE) && !rst;
    busy_o            = (state_q != IDLE);
    rf_we_o           = we_q && !rst;
    alu_active_o      = active_q && !rst;
    rf_raddr_o        = raddr_q;
    rf_waddr_o        = waddr_q;
    rf_wdata_o        = alu_result_i;
    alu_op_a_o        = op_a_q;
    alu_op_b_o        = op_b_q;
    alu_opcode_o      = opcode_q;
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small register file and ALU model.
module tb_alu_issue;
  logic        clk;
  logic        rst;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic [15:0] alu_op_a;
  logic [15:0] alu_op_b;
  logic [3:0]  alu_opcode;
  logic        alu_active;
  logic [15:0] alu_result;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        busy;

  logic        pl_we;
  logic [2:0]  pl_addr;
  logic [15:0] pl_data;
  logic [15:0] rf [8];
  logic        eq_q;

  int n_cmp;
  int n_bad;

  alu_issue_if #(.OPCODE_WIDTH(4), .REG_ADDR_WIDTH(3)) u_if ();

  alu_issue #(.DATA_WIDTH(16), .OPCODE_WIDTH(4), .REG_ADDR_WIDTH(3)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (u_if),
    .rf_raddr_o   (rf_raddr),
    .rf_rdata_i   (rf_rdata),
    .alu_op_a_o   (alu_op_a),
    .alu_op_b_o   (alu_op_b),
    .alu_opcode_o (alu_opcode),
    .alu_active_o (alu_active),
    .alu_result_i (alu_result),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: synchronous read, write at the edge, plus a bench preload port.
  always @(posedge clk) begin
    rf_rdata <= rf[rf_raddr];
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    if (pl_we) rf[pl_addr] <= pl_data;
  end

  // ALU model: ADD, SUB, NEG; anything else passes A.
  always_comb begin
    case (alu_opcode)
      4'h0:    alu_result = alu_op_a + alu_op_b;
      4'h1:    alu_result = alu_op_a - alu_op_b;
      4'h7:    alu_result = 16'h0000 - alu_op_a;
      default: alu_result = alu_op_a;
    endcase
  end

  // Compare flag updated on the ALU strobe.
  always @(posedge clk) begin
    if (rst) eq_q <= 1'b0;
    else if (alu_active) eq_q <= (alu_op_a == alu_op_b);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rf_load(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic present(input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] ra, input logic [2:0] rb);
    u_if.instr_valid  = 1'b1;
    u_if.instr_opcode = op;
    u_if.instr_rd     = rd;
    u_if.instr_ra     = ra;
    u_if.instr_rb     = rb;
`ifdef ALU_ISSUE_IMM_EN
    u_if.instr_use_imm = 1'b0;
    u_if.instr_imm     = 16'h0000;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    present(4'h0, 3'd0, 3'd0, 3'd0);
    u_if.instr_valid = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_ready", u_if.instr_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_we", rf_we, 1'b0);
    chk("rst_active", alu_active, 1'b0);
    chk("rst_opa", alu_op_a, 16'h0);
    chk("rst_opb", alu_op_b, 16'h0);
    chk("rst_opcode", alu_opcode, 4'h0);
    chk("rst_raddr", rf_raddr, 3'd0);
    chk("rst_waddr", rf_waddr, 3'd0);
    rst = 1'b0;
    #1 chk("rst_rel_ready", u_if.instr_ready, 1'b1);

    // ADD R3 = R1 + R2 = 12
    rf_load(3'd1, 16'd5);
    rf_load(3'd2, 16'd7);
    present(4'h0, 3'd3, 3'd1, 3'd2);
    @(negedge clk); u_if.instr_valid = 1'b0;           // T+1 RD_A
    chk("add_raddr_a", rf_raddr, 3'd1);
    chk("add_busy", busy, 1'b1);
    chk("add_ready_busy", u_if.instr_ready, 1'b0);
    @(negedge clk);                                    // T+2 RD_B
    chk("add_raddr_b", rf_raddr, 3'd2);
    @(negedge clk);                                    // T+3 CAP_B
    chk("add_capb_we", rf_we, 1'b0);
    chk("add_capb_active", alu_active, 1'b0);
    @(negedge clk);                                    // T+4 EXEC
    chk("add_we", rf_we, 1'b1);
    chk("add_active", alu_active, 1'b1);
    chk("add_waddr", rf_waddr, 3'd3);
    chk("add_wdata", rf_wdata, 16'd12);
    chk("add_opa", alu_op_a, 16'd5);
    chk("add_opb", alu_op_b, 16'd7);
    @(negedge clk);                                    // T+5 IDLE
    chk("add_ready_again", u_if.instr_ready, 1'b1);
    chk("add_we_done", rf_we, 1'b0);
    chk("add_active_done", alu_active, 1'b0);
    chk("add_rf3", rf[3], 16'd12);

    // CMP with R1 == R2 == 5: strobe, no write
    rf_load(3'd2, 16'd5);
    rf_load(3'd6, 16'h1234);
    present(4'h8, 3'd6, 3'd1, 3'd2);
    @(negedge clk); u_if.instr_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);    // T+4 EXEC
    chk("cmp_active", alu_active, 1'b1);
    chk("cmp_we", rf_we, 1'b0);
    chk("cmp_opcode", alu_opcode, 4'h8);
    @(negedge clk);                                    // T+5
    chk("cmp_equal", eq_q, 1'b1);
    chk("cmp_rf6", rf[6], 16'h1234);
    chk("cmp_opcode_hold", alu_opcode, 4'h8);

    // Back-to-back: SUB R4 = R2 - R1 = 2, then NEG R5 = -R4 = 0xFFFE
    rf_load(3'd2, 16'd7);
    present(4'h1, 3'd4, 3'd2, 3'd1);
    @(negedge clk);                                    // T+1
    present(4'h7, 3'd5, 3'd4, 3'd4);
    @(negedge clk); @(negedge clk); @(negedge clk);    // T+4 EXEC
    chk("b2b_sub_wdata", rf_wdata, 16'd2);
    chk("b2b_sub_waddr", rf_waddr, 3'd4);
    chk("b2b_ready_exec", u_if.instr_ready, 1'b0);
    @(negedge clk);                                    // T+5 IDLE, accepts
    chk("b2b_ready_t5", u_if.instr_ready, 1'b1);
    @(negedge clk); u_if.instr_valid = 1'b0;           // T+6 RD_A
    chk("b2b_neg_raddr", rf_raddr, 3'd4);
    @(negedge clk); @(negedge clk); @(negedge clk);    // T+9 EXEC
    chk("b2b_neg_we", rf_we, 1'b1);
    chk("b2b_neg_waddr", rf_waddr, 3'd5);
    chk("b2b_neg_wdata", rf_wdata, 16'hFFFE);
    @(negedge clk);
    chk("b2b_rf5", rf[5], 16'hFFFE);

`ifdef ALU_ISSUE_IMM_EN
    // Immediate: R7 = R1 + 0x10, CAP_B skipped
    @(negedge clk);
    present(4'h0, 3'd7, 3'd1, 3'd0);
    u_if.instr_use_imm = 1'b1;
    u_if.instr_imm     = 16'h0010;
    @(negedge clk); u_if.instr_valid = 1'b0;           // T+1
    @(negedge clk);                                    // T+2 RD_B
    chk("imm_rdb_we", rf_we, 1'b0);
    @(negedge clk);                                    // T+3 EXEC
    chk("imm_we", rf_we, 1'b1);
    chk("imm_wdata", rf_wdata, 16'h0015);
    chk("imm_waddr", rf_waddr, 3'd7);
    @(negedge clk);                                    // T+4
    chk("imm_ready", u_if.instr_ready, 1'b1);
    u_if.instr_use_imm = 1'b0;
`endif

    // Handshake: valid toggled with garbage fields while busy
    @(negedge clk);
    present(4'h1, 3'd6, 3'd2, 3'd1);                   // R6 = 7 - 5 = 2
    @(negedge clk);                                    // RD_A
    present(4'h8, 3'd0, 3'd7, 3'd7); u_if.instr_valid = 1'b0;
    chk("hs_raddr_a", rf_raddr, 3'd2);
    @(negedge clk); u_if.instr_valid = 1'b1;           // RD_B
    chk("hs_raddr_b", rf_raddr, 3'd1);
    @(negedge clk); u_if.instr_valid = 1'b0;           // CAP_B
    chk("hs_capb_busy", busy, 1'b1);
    @(negedge clk); u_if.instr_valid = 1'b1;           // EXEC
    chk("hs_opcode", alu_opcode, 4'h1);
    chk("hs_waddr", rf_waddr, 3'd6);
    chk("hs_wdata", rf_wdata, 16'd2);
    chk("hs_we", rf_we, 1'b1);
    @(negedge clk);                                    // IDLE
    chk("hs_idle_busy", busy, 1'b0);
    u_if.instr_valid = 1'b0;
    @(negedge clk);
    chk("hs_no_accept", busy, 1'b0);

    // Reset held 3 cycles mid-CAP_B
    rf_load(3'd3, 16'hAAAA);
    present(4'h0, 3'd3, 3'd1, 3'd2);
    @(negedge clk); u_if.instr_valid = 1'b0;
    @(negedge clk); @(negedge clk);                    // CAP_B
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstc_we", rf_we, 1'b0);
      chk("rstc_busy", busy, 1'b0);
      chk("rstc_ready", u_if.instr_ready, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rstc_ready_after", u_if.instr_ready, 1'b1);
    chk("rstc_opa", alu_op_a, 16'h0);
    chk("rstc_we_after", rf_we, 1'b0);
    chk("rstc_rf3", rf[3], 16'hAAAA);

    // Reset asserted during EXEC: write suppressed
    present(4'h0, 3'd3, 3'd1, 3'd2);
    @(negedge clk); u_if.instr_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);    // EXEC
    rst = 1'b1;
    #1 chk("rste_we", rf_we, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    chk("rste_rf3", rf[3], 16'hAAAA);
    chk("rste_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
